// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: fetch FSM states, default widths and the bubble instruction shared with PC and decode
package inst_fetch_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry instruction+pc4 park register (load wins over clear)
// ports: clk, reset_n (sync, active-low), load/clear, din/din_pc4 in, valid/data/pc4 out
module fetch_skid_buf import inst_fetch_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] din_pc4,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] pc4
);
  always_ff @(posedge clk)
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      pc4   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
      pc4   <= din_pc4;
    end else if (clear) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch with PC hold control, skid buffer and flush discard
// ports: clk, reset_n (sync, active-low); pc_in -> imem_addr; pc_stall to PC register;
//        imem_req/gnt/rvalid/rdata memory handshake; id_stall, flush from pipeline control;
//        ifid_valid/ifid_instr/ifid_pc4 IF/ID register
module inst_fetch import inst_fetch_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DEF_NOP_INSTR)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              id_stall,
  input  logic              flush,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4
);
  fetch_state_t state, state_nxt;
  logic [ADDR_W-1:0] req_addr, req_pc4, skid_pc4;
  logic [DATA_W-1:0] skid_data;
  logic skid_valid, got, parked, advance, skid_load, skid_clear;
  assign imem_addr  = pc_in;
  assign imem_req   = state == REQ;
  assign req_pc4    = req_addr + ADDR_W'(4);
  assign got        = state == WAIT && imem_rvalid;
  assign parked     = state == HOLD && skid_valid;
  assign advance    = (got | parked) & ~id_stall & ~flush;
  // combinational so the PC steps on the same edge the instruction lands in IF/ID
  assign pc_stall   = ~reset_n | state == IDLE | ~(advance | flush);
  assign skid_load  = got & id_stall & ~flush;
  assign skid_clear = parked & (flush | ~id_stall);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     state_nxt = imem_gnt ? (flush ? DROP : WAIT) : REQ;
      WAIT:    state_nxt = imem_rvalid ? ((flush | ~id_stall) ? REQ : HOLD) : (flush ? DROP : WAIT);
      HOLD:    state_nxt = (flush | ~id_stall) ? REQ : HOLD;
      DROP:    state_nxt = imem_rvalid ? REQ : DROP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state      <= IDLE;
      req_addr   <= '0;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
    end else begin
      state <= state_nxt;
      if (imem_req && imem_gnt) req_addr <= pc_in;
      if (flush || (!advance && !id_stall)) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end else if (advance) begin
        ifid_valid <= 1'b1;
        ifid_instr <= parked ? skid_data : imem_rdata;
        ifid_pc4   <= parked ? skid_pc4 : req_pc4;
      end
    end
  fetch_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .din     (imem_rdata),
    .din_pc4 (req_pc4),
    .valid   (skid_valid),
    .data    (skid_data),
    .pc4     (skid_pc4)
  );
endmodule
